// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: control, redirect and load inputs toward the fetch unit,
// plus the delivered-instruction outputs.
interface ifetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_start;
  logic                  i_step_mode;
  logic                  i_step;
  logic                  i_pcburbuja;
  logic [1:0]            i_select;
  logic [DATA_WIDTH-1:0] i_pc_branch;
  logic [DATA_WIDTH-1:0] i_pc_jump;
  logic                  i_loading;
  logic [DATA_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_instruccion;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_pc_incr;
  logic                  o_valid;
  logic                  o_halted;

  modport master (
    output i_start, i_step_mode, i_step, i_pcburbuja, i_select, i_pc_branch, i_pc_jump,
    output i_loading, i_address, i_instruccion,
    input  o_instruccion, o_pc_incr, o_valid, o_halted
  );

  modport slave (
    input  i_start, i_step_mode, i_step, i_pcburbuja, i_select, i_pc_branch, i_pc_jump,
    input  i_loading, i_address, i_instruccion,
    output o_instruccion, o_pc_incr, o_valid, o_halted
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: loadable instruction memory with synchronous read feeding a
// small prefetch queue, with redirect, stall, single-step and halt-on-HALT_WORD.
module ifetch_queue #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD   = '1
) (
  input logic           i_clock,
  input logic           i_reset,
  ifetch_queue_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem     [Words];
  logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];

  logic [DATA_WIDTH-1:0] pc_q, rd_data_q, rd_pc_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, occupancy;
  logic                  inflight_q, stopped_q;

  logic                  running, redirect, stop_now, issue, push, pop, valid;
  logic [DATA_WIDTH-1:0] target, fetch_pc, head_instr, head_pc;
  logic [ADDR_WIDTH-1:0] fetch_idx, write_idx;

  always_comb begin
    running   = (state_q == StRun);
    redirect  = running && (bus.i_select != 2'b00);
    target    = ((bus.i_select == 2'b01) ? bus.i_pc_branch : bus.i_pc_jump)
                & ~DATA_WIDTH'(3);
    // A redirect reads the target in the same cycle so it reaches the head two cycles later.
    fetch_pc  = redirect ? target : pc_q;
    fetch_idx = fetch_pc[ADDR_WIDTH+1:2];
    write_idx = bus.i_address[ADDR_WIDTH+1:2];
    occupancy = count_q + CntW'(inflight_q);
    // Also stop when a HALT_WORD is still in flight, so nothing past it gets fetched.
    stop_now  = stopped_q || (inflight_q && (rd_data_q == HALT_WORD));
    issue     = running && (redirect || (!stop_now && (occupancy < CntW'(QUEUE_DEPTH))));
    push      = running && inflight_q && !redirect;
    head_instr = q_instr[rd_ptr_q];
    head_pc    = q_pc[rd_ptr_q];
    valid     = running && (count_q != '0) && (bus.i_select == 2'b00);
    pop       = valid && !bus.i_pcburbuja && (!bus.i_step_mode || bus.i_step);
  end

  assign bus.o_valid       = valid;
  assign bus.o_instruccion = valid ? head_instr : '0;
  assign bus.o_pc_incr     = valid ? (head_pc + DATA_WIDTH'(4)) : '0;
  assign bus.o_halted      = (state_q == StHalted);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.i_start) state_d = StRun;
      StRun:    if (pop && (head_instr == HALT_WORD)) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      stopped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) pc_q <= fetch_pc + DATA_WIDTH'(4);
      if (redirect) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        stopped_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
          if (rd_data_q == HALT_WORD) stopped_q <= 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
          count_q <= count_q + CntW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CntW'(1);
        end
      end
    end
  end

  // Storage only; memory contents deliberately survive reset.
  always_ff @(posedge i_clock) begin
    if ((state_q == StIdle) && bus.i_loading) mem[write_idx] <= bus.i_instruccion;
    if (issue) begin
      rd_data_q <= mem[fetch_idx];
      rd_pc_q   <= fetch_pc;
    end
    if (push) begin
      q_instr[wr_ptr_q] <= rd_data_q;
      q_pc[wr_ptr_q]    <= rd_pc_q;
    end
  end

  logic unused_addr;
  assign unused_addr = ^bus.i_address;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: delivery order, stall fill, redirects, halt cancel,
// single-step and mid-run reset, each checked against hand-computed values.
module tb_ifetch_queue;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ifetch_queue_if #(.DATA_WIDTH(32)) bus ();

  ifetch_queue #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .QUEUE_DEPTH(4),
    .HALT_WORD  (HALT)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  task automatic idle_inputs();
    bus.i_start = 1'b0; bus.i_step_mode = 1'b0; bus.i_step = 1'b0; bus.i_pcburbuja = 1'b0;
    bus.i_select = 2'b00; bus.i_pc_branch = '0; bus.i_pc_jump = '0;
    bus.i_loading = 1'b0; bus.i_address = '0; bus.i_instruccion = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk); bus.i_loading = 1'b1; bus.i_address = addr; bus.i_instruccion = data;
    @(posedge clk); #1; bus.i_loading = 1'b0;
  endtask

  // Returns at the negedge of the first RUN cycle.
  task automatic start_run();
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_instruccion !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", bus.o_instruccion); end
    n_vec++; if (bus.o_pc_incr !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.o_pc_incr); end
    n_vec++; if (bus.o_halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", bus.o_halted); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_i [4] = '{32'h11, 32'h22, 32'h33, HALT};
    do_reset(); start_run(); #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat1 valid got %b want 0", bus.o_valid); end
    @(negedge clk); #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat2 valid got %b want 0", bus.o_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d] got %b want 1", i, bus.o_valid); end
      n_vec++; if (bus.o_instruccion !== exp_i[i]) begin n_err++; $display("FAIL basic_instr[%0d] got %h want %h", i, bus.o_instruccion, exp_i[i]); end
      n_vec++; if (bus.o_pc_incr !== 32'(4 * (i + 1))) begin n_err++; $display("FAIL basic_pc[%0d] got %h want %h", i, bus.o_pc_incr, 4 * (i + 1)); end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.o_halted !== 1'b1) begin n_err++; $display("FAIL basic_halted got %b want 1", bus.o_halted); end
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_halt_valid got %b want 0", bus.o_valid); end
    // This write must be ignored while halted; the reset test re-reads word 0.
    bus.i_loading = 1'b1; bus.i_address = 32'h0; bus.i_instruccion = 32'hDEAD;
    @(negedge clk); bus.i_loading = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] exp_i [4] = '{32'h11, 32'h22, 32'h33, HALT};
    do_reset(); bus.i_pcburbuja = 1'b1; start_run();
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk); #1;
      if (c >= 3) begin
        n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== 32'h11) begin n_err++; $display("FAIL stall_hold[%0d] got %b/%h want 1/00000011", c, bus.o_valid, bus.o_instruccion); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (i == 0) bus.i_pcburbuja = 1'b0; #1;
      n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== exp_i[i]) begin n_err++; $display("FAIL stall_drain[%0d] got %b/%h want 1/%h", i, bus.o_valid, bus.o_instruccion, exp_i[i]); end
      n_vec++; if (bus.o_pc_incr !== 32'(4 * (i + 1))) begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", i, bus.o_pc_incr, 4 * (i + 1)); end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.o_halted !== 1'b1) begin n_err++; $display("FAIL stall_halted got %b want 1", bus.o_halted); end
  endtask

  task automatic test_branch();
    do_reset(); start_run();
    @(negedge clk);
    @(negedge clk); bus.i_select = 2'b01; bus.i_pc_branch = 32'h40; bus.i_pc_jump = 32'h80; #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL branch_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_instruccion !== 32'h0) begin n_err++; $display("FAIL branch_instr got %h want 0", bus.o_instruccion); end
    n_vec++; if (bus.o_pc_incr !== 32'h0) begin n_err++; $display("FAIL branch_pc got %h want 0", bus.o_pc_incr); end
    @(negedge clk); bus.i_select = 2'b00; #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL branch_gap got %b want 0", bus.o_valid); end
    @(negedge clk); #1;
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== 32'hAA) begin n_err++; $display("FAIL branch_target got %b/%h want 1/000000aa", bus.o_valid, bus.o_instruccion); end
    n_vec++; if (bus.o_pc_incr !== 32'h44) begin n_err++; $display("FAIL branch_target_pc got %h want 44", bus.o_pc_incr); end
    @(negedge clk); #1;
    n_vec++; if (bus.o_instruccion !== 32'hBB || bus.o_pc_incr !== 32'h48) begin n_err++; $display("FAIL branch_next got %h/%h want 000000bb/48", bus.o_instruccion, bus.o_pc_incr); end
  endtask

  task automatic test_halt_cancel();
    logic [31:0] exp_i [4] = '{32'hAA, 32'hBB, 32'hCC, HALT};
    do_reset(); bus.i_pcburbuja = 1'b1; start_run();
    repeat (7) @(negedge clk);
    #1;
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== 32'h11) begin n_err++; $display("FAIL cancel_full got %b/%h want 1/00000011", bus.o_valid, bus.o_instruccion); end
    // Select 11 behaves as jump; misaligned target must be word-aligned.
    @(negedge clk); bus.i_select = 2'b11; bus.i_pc_jump = 32'h43; bus.i_pc_branch = 32'h80;
    bus.i_pcburbuja = 1'b0; #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL cancel_redirect_valid got %b want 0", bus.o_valid); end
    @(negedge clk); bus.i_select = 2'b00; #1;
    n_vec++; if (bus.o_valid !== 1'b0 || bus.o_halted !== 1'b0) begin n_err++; $display("FAIL cancel_gap got %b/%b want 0/0", bus.o_valid, bus.o_halted); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== exp_i[i]) begin n_err++; $display("FAIL cancel_seq[%0d] got %b/%h want 1/%h", i, bus.o_valid, bus.o_instruccion, exp_i[i]); end
      n_vec++; if (bus.o_pc_incr !== 32'(32'h44 + 4 * i) || bus.o_halted !== 1'b0) begin n_err++; $display("FAIL cancel_pc[%0d] got %h/%b want %h/0", i, bus.o_pc_incr, bus.o_halted, 32'h44 + 4 * i); end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.o_halted !== 1'b1) begin n_err++; $display("FAIL cancel_final_halt got %b want 1", bus.o_halted); end
  endtask

  task automatic test_step();
    logic [31:0] exp_i [4] = '{32'h11, 32'h22, 32'h33, HALT};
    int idx;
    do_reset(); bus.i_step_mode = 1'b1; start_run(); bus.i_step = 1'b1; #1;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL step_early_valid got %b want 0", bus.o_valid); end
    @(negedge clk); bus.i_step = 1'b0;
    for (int r = 3; r <= 17; r++) begin
      @(negedge clk); bus.i_step = (r == 5 || r == 10 || r == 15); #1;
      idx = int'(r > 5) + int'(r > 10) + int'(r > 15);
      n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== exp_i[idx]) begin n_err++; $display("FAIL step_head[%0d] got %b/%h want 1/%h", r, bus.o_valid, bus.o_instruccion, exp_i[idx]); end
    end
    @(negedge clk); bus.i_step = 1'b0; #1;
    n_vec++; if (bus.o_halted !== 1'b0 || bus.o_pc_incr !== 32'h10) begin n_err++; $display("FAIL step_end got %b/%h want 0/10", bus.o_halted, bus.o_pc_incr); end
  endtask

  task automatic test_reset_midrun();
    do_reset(); start_run();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++; if (bus.o_instruccion !== 32'h22 || bus.o_pc_incr !== 32'h8) begin n_err++; $display("FAIL mid_pre got %h/%h want 00000022/8", bus.o_instruccion, bus.o_pc_incr); end
    @(negedge clk); rst = 1'b1; #1;
    n_vec++; if (bus.o_valid !== 1'b0 || bus.o_instruccion !== 32'h0) begin n_err++; $display("FAIL mid_rst_out got %b/%h want 0/0", bus.o_valid, bus.o_instruccion); end
    n_vec++; if (bus.o_pc_incr !== 32'h0 || bus.o_halted !== 1'b0) begin n_err++; $display("FAIL mid_rst_pc got %h/%b want 0/0", bus.o_pc_incr, bus.o_halted); end
    @(negedge clk); rst = 1'b0;
    start_run();
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_instruccion !== 32'h11 || bus.o_pc_incr !== 32'h4) begin n_err++; $display("FAIL mid_restart got %b/%h/%h want 1/00000011/4", bus.o_valid, bus.o_instruccion, bus.o_pc_incr); end
    @(negedge clk); #1;
    n_vec++; if (bus.o_instruccion !== 32'h22 || bus.o_pc_incr !== 32'h8) begin n_err++; $display("FAIL mid_second got %h/%h want 00000022/8", bus.o_instruccion, bus.o_pc_incr); end
  endtask

  initial begin
    test_reset();
    load_word(32'h00, 32'h11);
    load_word(32'h04, 32'h22);
    load_word(32'h08, 32'h33);
    load_word(32'h0C, HALT);
    load_word(32'h40, 32'hAA);
    load_word(32'h44, 32'hBB);
    load_word(32'h48, 32'hCC);
    load_word(32'h4C, HALT);
    load_word(32'h80, 32'h99);
    test_basic();
    test_stall();
    test_branch();
    test_halt_cancel();
    test_step();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and PC width.
REQ-002 Parameter ADDR_WIDTH, default 8: word-address bits of the internal instruction memory (2^ADDR_WIDTH words).
REQ-003 Parameter QUEUE_DEPTH, default 4: prefetch queue entries; power of 2, minimum 2.
REQ-004 Parameter HALT_WORD, default all-ones: instruction encoding that halts fetch.
REQ-005 i_clock  in  1  sole clock; all state updates on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_start  in  1  level; leaves IDLE and begins fetching from PC 0.
REQ-008 i_step_mode  in  1  1 = debug single-step delivery.
REQ-009 i_step  in  1  one-cycle pulse; allows one handoff while i_step_mode=1.
REQ-010 i_pcburbuja  in  1  downstream stall; no handoff while 1.
REQ-011 i_select  in  2  00 sequential, 01 branch, 10 jump, 11 treated as jump.
REQ-012 i_pc_branch, i_pc_jump  in  DATA_WIDTH  byte redirect targets.
REQ-013 i_loading, i_address, i_instruccion  in  1/DATA_WIDTH/DATA_WIDTH  memory write port; i_address is a byte address.
REQ-014 o_instruccion  out  DATA_WIDTH  queue head instruction; 0 (NOP) when o_valid=0.
REQ-015 o_pc_incr  out  DATA_WIDTH  head instruction byte PC + 4; 0 when o_valid=0.
REQ-016 o_valid  out  1  head instruction is handed off this cycle unless stalled.
REQ-017 o_halted  out  1  HALTED state indicator.

Function
REQ-018 States: IDLE, RUN, HALTED; IDLE->RUN when i_start=1; RUN->HALTED on handoff of HALT_WORD; HALTED exits only by reset.
REQ-019 Memory writes occur only in IDLE with i_loading=1: word[i_address[ADDR_WIDTH+1:2]] <= i_instruccion; ignored otherwise.
REQ-020 Memory read is synchronous: address issued in cycle n, data written into queue at edge ending cycle n+1.
REQ-021 Fetch issue in RUN only when (queue count + in-flight reads) < QUEUE_DEPTH and fetch not stopped; each issue sets PC <= PC+4.
REQ-022 Address bits above ADDR_WIDTH+1 are ignored; PC wraps modulo memory size without error.
REQ-023 Handoff condition: o_valid=1 and i_pcburbuja=0 and (i_step_mode=0 or i_step=1); handoff pops the queue.
REQ-024 o_valid = RUN and queue not empty and i_select=00; o_instruccion/o_pc_incr are combinational from queue head.
REQ-025 i_select!=00 in RUN: no handoff that cycle, queue flushed, in-flight read discarded, PC <= target, fetch-stopped cleared; first target instruction presented at o_valid 2 cycles later.
REQ-026 Queue simultaneous push and pop keeps count unchanged; pop on empty and push on full never occur.
REQ-027 HALT_WORD entering the queue sets fetch-stopped; it is still delivered in order; a redirect before its handoff cancels the halt.
REQ-028 In HALTED: o_valid=0, no fetch, no memory write, o_halted=1.
REQ-029 i_step pulses while o_valid=0 are dropped, not remembered.
REQ-030 Target low two bits are forced to 0 when loaded into PC.

Reset
REQ-031 i_reset=1 immediately forces: state IDLE, PC 0, queue empty, in-flight cleared, fetch-stopped 0, o_valid 0, o_instruccion 0, o_pc_incr 0, o_halted 0.
REQ-032 Memory contents are not cleared by reset; reset mid-run discards all queued and in-flight instructions.

Verification
REQ-033 Load words 0..3 = 0x11,0x22,0x33,HALT_WORD, start, stall 0 -> handoffs 0x11/4, 0x22/8, 0x33/12, HALT/16 on consecutive cycles after first, then o_halted=1.
REQ-034 Same program, i_pcburbuja=1 for 10 cycles after start -> queue fills to 4, no extra issue, then 4 back-to-back handoffs after release.
REQ-035 i_select=01, i_pc_branch=0x40 while head valid -> that cycle o_valid=0, o_instruccion=0; 2 cycles later head = word 16, o_pc_incr=0x44.
REQ-036 Redirect issued while HALT_WORD queued behind head -> halt cancelled, o_halted stays 0, fetch continues at target.
REQ-037 i_step_mode=1, three i_step pulses spaced 5 cycles -> exactly three handoffs, one per pulse.
REQ-038 Assert i_reset mid-run then i_start -> outputs zero during reset, program re-delivered from PC 0 with memory intact.
